or4_sweep_ctrl: RTL

Synchronous sequencer that exhaustively exercises a 4-input OR unit (any OR4 implementation variant) in hardware. It drives all 16 input patterns in ascending order, holds each for a programmable settle time, samples the unit's output, compares it against the expected OR and accumulates a mismatch count. It sits between a start/status register interface and the unit under check, replacing the delay-based stimulus loop with a clocked, self-checking sweep.

---
 rtl/or4_sweep_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/or4_sweep_ctrl.sv
// Clocked self-checking sweep of a 4-input OR unit: drives all 16 vectors, samples i_f after a settle time, counts mismatches.
// Optional OR4_SWEEP_STOP_ON_ERR_EN: halt the sweep on the first mismatch.
module or4_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_f,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic       o_d,
  output logic [3:0] o_vec,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [4:0] o_err_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_n;
  logic [3:0] vec, vec_n;
  logic [3:0] cnt, cnt_n;
  logic [4:0] err, err_n;
  logic       busy_n, done_n, pass_n;
  logic [3:0] drive_n;
  logic       mismatch;
  logic       halt;

  assign mismatch = (i_f != (|vec));

`ifdef OR4_SWEEP_STOP_ON_ERR_EN
  assign halt = mismatch;
`else
  assign halt = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      vec     <= '0;
      cnt     <= '0;
      err     <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_pass  <= 1'b0;
      {o_a, o_b, o_c, o_d} <= '0;
    end else begin
      state   <= state_n;
      vec     <= vec_n;
      cnt     <= cnt_n;
      err     <= err_n;
      o_busy  <= busy_n;
      o_done  <= done_n;
      o_pass  <= pass_n;
      {o_a, o_b, o_c, o_d} <= drive_n;
    end
  end

  always_comb begin
    state_n = state;
    vec_n   = vec;
    cnt_n   = cnt;
    err_n   = err;
    case (state)
      IDLE, DONE: begin
        if (i_start) begin
          vec_n   = '0;
          cnt_n   = '0;
          err_n   = '0;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        cnt_n = cnt + 4'd1;
        if (cnt == LAST_CNT) state_n = CHECK;
      end
      CHECK: begin
        if (mismatch) err_n = err + 5'd1;
        // Vector 15 never wraps: its check always ends the sweep.
        if (halt || vec == '1) begin
          state_n = DONE;
        end else begin
          vec_n   = vec + 4'd1;
          cnt_n   = '0;
          state_n = SETTLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered, so they are computed from the next-state values.
  always_comb begin
    busy_n  = (state_n == SETTLE) || (state_n == CHECK);
    done_n  = (state_n == DONE);
    pass_n  = done_n && (err_n == '0);
    drive_n = (state_n == IDLE) ? '0 : vec_n;
  end

  assign o_vec     = vec;
  assign o_err_cnt = err;

endmodule
